// File: rtl/cci_c1_wrreq_buffer_if.sv
// Upstream request handshake plus CCI TX channel 1 bus for the write-request buffer.
interface cci_c1_wrreq_buffer_if #(
  parameter int TX_HDR_W = 61,
  parameter int DATA_W   = 512
);
  logic                in_valid;
  logic                in_ready;
  logic [TX_HDR_W-1:0] in_hdr;
  logic [DATA_W-1:0]   in_data;
  logic [TX_HDR_W-1:0] tx_c1_header;
  logic [DATA_W-1:0]   tx_c1_data;
  logic                tx_c1_wrvalid;
  logic                tx_c1_almostfull;

  // slave is the buffer's view; master is the surrounding AFU/CCI environment
  modport slave (
    input  in_valid, in_hdr, in_data, tx_c1_almostfull,
    output in_ready, tx_c1_header, tx_c1_data, tx_c1_wrvalid
  );
  modport master (
    output in_valid, in_hdr, in_data, tx_c1_almostfull,
    input  in_ready, tx_c1_header, tx_c1_data, tx_c1_wrvalid
  );
endinterface

// File: rtl/cci_c1_wrreq_buffer.sv
// CCI TX channel 1 write-request staging FIFO with outstanding tracking and drain handshake.
// Define CCI_WRBUF_STATS_EN to add the stat_wr_issued / stat_af_stall counters.
module cci_c1_wrreq_buffer #(
  parameter int TX_HDR_W = 61,
  parameter int DATA_W   = 512,
  parameter int DEPTH    = 8,
  parameter int MAX_OUT  = 32
) (
  input  logic                         clk_32ui,
  input  logic                         sys_reset_n,
  cci_c1_wrreq_buffer_if.slave         bus,
  input  logic                         rx_c0_wrvalid,
  input  logic                         rx_c1_wrvalid,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         err_underflow
`ifdef CCI_WRBUF_STATS_EN
  ,
  output logic [31:0]                  stat_wr_issued,
  output logic [31:0]                  stat_af_stall
`endif
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = TX_HDR_W + DATA_W;

  // RUN accept+issue | DRAIN issue only | DONE drain_done pulse | HOLD wait for drain_req low
  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;
  state_t state;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [OW:0]   out_sum, out_dec;
  logic [OW-1:0] out_next;
  logic          underflow;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = !full && (state == RUN);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && !bus.tx_c1_almostfull && (outstanding < OW'(MAX_OUT));

  always_comb begin
    out_sum   = {1'b0, outstanding} + (OW+1)'(pop);
    out_dec   = (OW+1)'(rx_c0_wrvalid) + (OW+1)'(rx_c1_wrvalid);
    underflow = (out_dec > out_sum);
    out_next  = underflow ? '0 : OW'(out_sum - out_dec);
  end

  // storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk_32ui) begin
    if (push) mem[wr_ptr] <= {bus.in_hdr, bus.in_data};
  end

  always_ff @(posedge clk_32ui) begin
    if (!sys_reset_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.tx_c1_wrvalid <= 1'b0;
      bus.tx_c1_header  <= '0;
      bus.tx_c1_data    <= '0;
      outstanding       <= '0;
      err_underflow     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      bus.tx_c1_wrvalid <= pop;
      if (pop) {bus.tx_c1_header, bus.tx_c1_data} <= mem[rd_ptr];
      outstanding <= out_next;
      if (underflow) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_32ui) begin
    if (!sys_reset_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        RUN:   if (drain_req) state <= DRAIN;
        DRAIN: if (empty && (outstanding == '0) && !bus.tx_c1_wrvalid) begin
                 state      <= DONE;
                 drain_done <= 1'b1;
               end
        DONE:  state <= drain_req ? HOLD : RUN;
        HOLD:  if (!drain_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef CCI_WRBUF_STATS_EN
  always_ff @(posedge clk_32ui) begin
    if (!sys_reset_n) begin
      stat_wr_issued <= '0;
      stat_af_stall  <= '0;
    end else begin
      if (bus.tx_c1_wrvalid && (stat_wr_issued != '1))
        stat_wr_issued <= stat_wr_issued + 32'd1;
      if (!empty && bus.tx_c1_almostfull && (stat_af_stall != '1))
        stat_af_stall <= stat_af_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cci_c1_wrreq_buffer.sv
// Directed bench for cci_c1_wrreq_buffer: vector table plus hand-written corner sequences.
module tb_cci_c1_wrreq_buffer;
  localparam int TX_HDR_W = 61;
  localparam int DATA_W   = 512;

  logic clk_32ui = 1'b0;
  logic sys_reset_n;
  logic rx_c0_wrvalid, rx_c1_wrvalid, drain_req;
  logic drain_done, err_underflow;
  logic [5:0] outstanding;
`ifdef CCI_WRBUF_STATS_EN
  logic [31:0] stat_wr_issued, stat_af_stall;
`endif

  cci_c1_wrreq_buffer_if #(.TX_HDR_W(TX_HDR_W), .DATA_W(DATA_W)) bus ();

  cci_c1_wrreq_buffer #(.TX_HDR_W(TX_HDR_W), .DATA_W(DATA_W), .DEPTH(8), .MAX_OUT(32)) dut (
    .clk_32ui      (clk_32ui),
    .sys_reset_n   (sys_reset_n),
    .bus           (bus),
    .rx_c0_wrvalid (rx_c0_wrvalid),
    .rx_c1_wrvalid (rx_c1_wrvalid),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
`ifdef CCI_WRBUF_STATS_EN
    ,
    .stat_wr_issued(stat_wr_issued),
    .stat_af_stall (stat_af_stall)
`endif
  );

  always #5 clk_32ui = ~clk_32ui;

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;

  always @(negedge clk_32ui) if (drain_done === 1'b1) done_pulses++;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       iv;
    logic [7:0] hdr;
    logic       af, r0, r1;
    logic       e_wv;
    logic [7:0] e_hdr;
    logic [5:0] e_out;
    logic       e_rdy, e_err;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [DATA_W-1:0] mkdata(input logic [7:0] h);
    return {16{24'hC0FFEE, h}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_32ui);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] h);
    bus.in_valid = iv;
    bus.in_hdr   = TX_HDR_W'(h);
    bus.in_data  = mkdata(h);
  endtask

  task automatic do_reset();
    sys_reset_n = 1'b0;
    drive(1'b0, 8'h0);
    rx_c0_wrvalid = 1'b0;
    rx_c1_wrvalid = 1'b0;
    drain_req = 1'b0;
    tick();
    sys_reset_n = 1'b1;
  endtask

  initial begin
    int wv_seen, idx, iss, cyc, p0;
    logic pushed;

    //            iv  hdr    af r0 r1 | wv hdr   out rdy err
    vecs[0]  = '{1'b1, 8'h1, 0, 0, 0,  0, 8'h0, 0,  1,  0};
    vecs[1]  = '{1'b1, 8'h2, 0, 0, 0,  1, 8'h1, 1,  1,  0};
    vecs[2]  = '{1'b1, 8'h3, 0, 0, 0,  1, 8'h2, 2,  1,  0};
    vecs[3]  = '{1'b0, 8'h0, 0, 0, 0,  1, 8'h3, 3,  1,  0};
    vecs[4]  = '{1'b0, 8'h0, 0, 0, 0,  0, 8'h3, 3,  1,  0};
    vecs[5]  = '{1'b1, 8'h4, 0, 0, 0,  0, 8'h3, 3,  1,  0};
    vecs[6]  = '{1'b1, 8'h5, 0, 0, 0,  1, 8'h4, 4,  1,  0};
    vecs[7]  = '{1'b1, 8'h6, 0, 0, 0,  1, 8'h5, 5,  1,  0};
    vecs[8]  = '{1'b0, 8'h0, 0, 1, 1,  1, 8'h6, 4,  1,  0};
    vecs[9]  = '{1'b0, 8'h0, 0, 1, 1,  0, 8'h6, 2,  1,  0};
    vecs[10] = '{1'b0, 8'h0, 0, 1, 1,  0, 8'h6, 0,  1,  0};
    vecs[11] = '{1'b0, 8'h0, 0, 0, 1,  0, 8'h6, 0,  1,  1};
    vecs[12] = '{1'b0, 8'h0, 0, 0, 0,  0, 8'h6, 0,  1,  1};

    bus.tx_c1_almostfull = 1'b0;
    sys_reset_n = 1'b0;
    drive(1'b0, 8'h0);
    rx_c0_wrvalid = 1'b0;
    rx_c1_wrvalid = 1'b0;
    drain_req = 1'b0;
    tick();
    tick();
    sys_reset_n = 1'b1;

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wrvalid", 64'(bus.tx_c1_wrvalid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_header", 64'(bus.tx_c1_header), 64'd0);

    // issue order, outstanding arithmetic, double response, underflow
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].hdr);
      bus.tx_c1_almostfull = vecs[i].af;
      rx_c0_wrvalid = vecs[i].r0;
      rx_c1_wrvalid = vecs[i].r1;
      tick();
      chk($sformatf("v%0d_wrvalid", i), 64'(bus.tx_c1_wrvalid), 64'(vecs[i].e_wv));
      chk($sformatf("v%0d_header", i), 64'(bus.tx_c1_header), 64'(vecs[i].e_hdr));
      chk($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_err", i), 64'(err_underflow), 64'(vecs[i].e_err));
      if (vecs[i].e_wv)
        chk($sformatf("v%0d_data", i), 64'(bus.tx_c1_data === mkdata(vecs[i].e_hdr)), 64'd1);
    end
    rx_c0_wrvalid = 1'b0;
    rx_c1_wrvalid = 1'b0;
`ifdef CCI_WRBUF_STATS_EN
    chk("stat_wr_issued", 64'(stat_wr_issued), 64'd6);
`endif

    // fill under almostfull, then release
    do_reset();
    bus.tx_c1_almostfull = 1'b1;
    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h10 + 8'(i));
      tick();
      if (bus.tx_c1_wrvalid) wv_seen++;
    end
    drive(1'b0, 8'h0);
    chk("af_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("af_no_issue", 64'(wv_seen), 64'd0);
    bus.tx_c1_almostfull = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("af_rel%0d_wrvalid", i), 64'(bus.tx_c1_wrvalid), 64'd1);
      chk($sformatf("af_rel%0d_header", i), 64'(bus.tx_c1_header), 64'(8'h10 + 8'(i)));
      if (i == 0) chk("af_rel_in_ready", 64'(bus.in_ready), 64'd1);
    end
    tick();
    chk("af_rel_end_wrvalid", 64'(bus.tx_c1_wrvalid), 64'd0);
    chk("af_rel_outstanding", 64'(outstanding), 64'd8);

    // MAX_OUT stall: push 33, only 32 issue until a response arrives
    do_reset();
    idx = 0; iss = 0; cyc = 0;
    while (idx < 33 && cyc < 300) begin
      drive(1'b1, 8'(idx));
      pushed = bus.in_ready;
      tick();
      cyc++;
      if (pushed) idx++;
      if (bus.tx_c1_wrvalid) begin
        chk($sformatf("max_issue%0d_header", iss), 64'(bus.tx_c1_header), 64'(iss));
        iss++;
      end
    end
    drive(1'b0, 8'h0);
    chk("max_pushed", 64'(idx), 64'd33);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx_c1_wrvalid) iss++;
    end
    chk("max_issued", 64'(iss), 64'd32);
    chk("max_outstanding", 64'(outstanding), 64'd32);
    rx_c1_wrvalid = 1'b1;
    tick();
    rx_c1_wrvalid = 1'b0;
    chk("max_resp_outstanding", 64'(outstanding), 64'd31);
    chk("max_resp_wrvalid", 64'(bus.tx_c1_wrvalid), 64'd0);
    tick();
    chk("max_33_wrvalid", 64'(bus.tx_c1_wrvalid), 64'd1);
    chk("max_33_header", 64'(bus.tx_c1_header), 64'd32);
    chk("max_33_outstanding", 64'(outstanding), 64'd32);

    // drain with 4 buffered and 2 outstanding
    do_reset();
    drive(1'b1, 8'h40); tick();
    drive(1'b1, 8'h41); tick();
    drive(1'b0, 8'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("drn_pre_outstanding", 64'(outstanding), 64'd2);
    bus.tx_c1_almostfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h50 + 8'(i));
      tick();
    end
    drive(1'b0, 8'h0);
    p0 = done_pulses;
    drain_req = 1'b1;
    tick();
    chk("drn_in_ready", 64'(bus.in_ready), 64'd0);
    bus.tx_c1_almostfull = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("drn_issue_outstanding", 64'(outstanding), 64'd6);
    chk("drn_no_early_done", 64'(done_pulses - p0), 64'd0);
    rx_c0_wrvalid = 1'b1;
    rx_c1_wrvalid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rx_c0_wrvalid = 1'b0;
    rx_c1_wrvalid = 1'b0;
    // counter reads 0 here; the FSM sees it on the next edge
    chk("drn_zero_outstanding", 64'(outstanding), 64'd0);
    chk("drn_done_not_yet", 64'(drain_done), 64'd0);
    tick();
    chk("drn_done_pulse", 64'(drain_done), 64'd1);
    tick();
    chk("drn_done_cleared", 64'(drain_done), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("drn_hold_in_ready", 64'(bus.in_ready), 64'd0);
    chk("drn_single_pulse", 64'(done_pulses - p0), 64'd1);
    drain_req = 1'b0;
    tick();
    chk("drn_release_in_ready", 64'(bus.in_ready), 64'd1);

    // drain from idle
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("idle_drn_c1", 64'(drain_done), 64'd0);
    tick();
    chk("idle_drn_c2", 64'(drain_done), 64'd1);
    tick();
    chk("idle_drn_c3", 64'(drain_done), 64'd0);
    chk("idle_drn_in_ready", 64'(bus.in_ready), 64'd1);

    // mid-operation reset
    rx_c0_wrvalid = 1'b1;
    tick();
    rx_c0_wrvalid = 1'b0;
    chk("mr_err_set", 64'(err_underflow), 64'd1);
    drive(1'b1, 8'h60); tick();
    drive(1'b1, 8'h61); tick();
    drive(1'b0, 8'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("mr_pre_outstanding", 64'(outstanding), 64'd2);
    bus.tx_c1_almostfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h70 + 8'(i));
      tick();
    end
    p0 = done_pulses;
    do_reset();
    chk("mr_outstanding", 64'(outstanding), 64'd0);
    chk("mr_err", 64'(err_underflow), 64'd0);
    chk("mr_wrvalid", 64'(bus.tx_c1_wrvalid), 64'd0);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    bus.tx_c1_almostfull = 1'b0;
    wv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.tx_c1_wrvalid) wv_seen++;
    end
    chk("mr_fifo_empty", 64'(wv_seen), 64'd0);
    chk("mr_no_done", 64'(done_pulses - p0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cci_c1_wrreq_buffer.md
Name: cci_c1_wrreq_buffer

Overview:
- Write-request staging buffer directly upstream of the CCI TX channel 1 of the emulator/AFU boundary.
- Accepts header+data write requests from AFU-side logic into a FIFO.
- Issues requests onto tx_c1_header/tx_c1_data/tx_c1_wrvalid, honouring tx_c1_almostfull.
- Counts outstanding writes until write responses (rx_c0_wrvalid, rx_c1_wrvalid) return, and supports a drain handshake for soft-reset/teardown sequencing.

Parameters:
- TX_HDR_W, 61, TX header width (matches CCI TX header width).
- DATA_W, 512, cache-line data width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- MAX_OUT, 32, maximum outstanding writes; issue stalls at this count.

Ports:
- clk_32ui  in  1  sole clock, CCI link-protocol 32ui domain
- sys_reset_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  buffer can accept; equals !full && state==RUN
- in_hdr  in  TX_HDR_W  request header
- in_data  in  DATA_W  request data
- tx_c1_header  out  TX_HDR_W  header to CCI TX channel 1
- tx_c1_data  out  DATA_W  data to CCI TX channel 1
- tx_c1_wrvalid  out  1  write request valid, one cycle per request
- tx_c1_almostfull  in  1  CCI flow control
- rx_c0_wrvalid  in  1  write response on channel 0
- rx_c1_wrvalid  in  1  write response on channel 1
- drain_req  in  1  level; request drain
- drain_done  out  1  one-cycle pulse when drain completes
- outstanding  out  $clog2(MAX_OUT+1)  current outstanding writes
- err_underflow  out  1  sticky; response received with outstanding==0

Behaviour:
- Reset (sys_reset_n=0 sampled at clk_32ui edge):
  - FIFO flushed; pointers and count set to 0; state RUN.
  - All outputs 0 except in_ready, which is 1 on the first cycle after reset.
  - Reset mid-operation discards buffered and in-flight tracking with no drain_done pulse.
- Push: in_valid && in_ready writes {in_hdr, in_data} at the write pointer.
  - Pointers wrap modulo DEPTH.
  - Full = count==DEPTH.
- Pop condition in cycle N: !empty && !tx_c1_almostfull && outstanding<MAX_OUT.
  - Registered outputs in N+1: tx_c1_wrvalid=1 with the head entry's header/data.
  - Otherwise tx_c1_wrvalid=0 and header/data hold their last values.
- Latency:
  - Entry pushed in cycle N is poppable from N+1 and appears on tx_c1 in N+2 at minimum.
  - No push-to-output bypass.
- Simultaneous push and pop when full: not permitted, since in_ready=0 while full.
- Simultaneous push and pop at count 1..DEPTH-1: count is unchanged.
- Almostfull:
  - Sampled combinationally in the pop cycle.
  - At most one further tx_c1_wrvalid follows its assertion, namely the registered one already decided.
- Outstanding counter, per cycle: next = cur + pop − rx_c0_wrvalid − rx_c1_wrvalid.
  - Both responses in one cycle decrement by 2.
  - Pop and response in the same cycle net out.
- Underflow: if the decrement exceeds cur+pop, the counter saturates at 0 and err_underflow sets.
  - err_underflow is cleared only by reset.
- FSM:
  - RUN: in_ready=!full. drain_req=1 -> DRAIN.
  - DRAIN: in_ready=0; issue continues. When empty && outstanding==0 && tx_c1_wrvalid==0 -> DONE.
  - DONE: drain_done=1 for one cycle. -> RUN if drain_req=0, else -> HOLD.
  - HOLD: in_ready=0, no pulse. drain_req=0 -> RUN.
- drain_req asserted when already idle (empty, 0 outstanding): RUN->DRAIN->DONE, so drain_done pulses 2 cycles after drain_req is sampled.

Optional Feature:
- Macro: CCI_WRBUF_STATS_EN.
- When defined, adds these outputs:
  - stat_wr_issued (32b): increments on each tx_c1_wrvalid.
  - stat_af_stall (32b): increments each cycle with !empty && tx_c1_almostfull.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Push 3 requests (hdr 0x1,0x2,0x3) back-to-back, almostfull=0 -> tx_c1_wrvalid in cycles 2,3,4 after the first push, in order; outstanding reaches 3.
- Fill 8 entries with almostfull=1 -> in_ready=0 after the 8th push, no tx_c1_wrvalid. Deassert almostfull -> 8 consecutive wrvalids; in_ready returns 1 the cycle after the first pop.
- 32 issued, no responses -> 33rd entry held. Single rx_c1_wrvalid -> outstanding 31, 33rd issued next cycle, outstanding back to 32.
- rx_c0_wrvalid and rx_c1_wrvalid together with outstanding=5 and a pop that cycle -> outstanding=4. Response pulse at outstanding=0 with no pop -> outstanding stays 0, err_underflow=1 and stays 1.
- 4 buffered, 2 outstanding, drain_req=1 -> in_ready=0 immediately; drain_done pulses once, one cycle after the last response returns with FIFO empty. Holding drain_req keeps in_ready=0 until release.
- Assert sys_reset_n=0 for 1 cycle with 5 buffered -> FIFO empty, outstanding 0, no tx_c1_wrvalid, err_underflow 0, no drain_done pulse.
